dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Direct-mapped, one-word-per-line, write-through, no-write-allocate data cache controller.
- Sits between the load/store unit and the byte-addressed data RAM (little-endian, combinational word read, clocked sb/sh/sw byte-lane writes).
- Sequences all RAM accesses. Serves load hits in zero added cycles. Models RAM read latency with a counter on misses and stalls the CPU while busy.

Parameters:
- ADDRESS_LENGTH, 32, address and data width.
- SETS, 8, number of lines (power of 2); INDEX_BITS = log2(SETS).
- MEM_LATENCY, 2, wait cycles charged per RAM read on a miss (>=1).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  access request; held stable by the CPU while cpu_stall=1.
- cpu_we  in  1  1=store, 0=load.
- cpu_size  in  2  00 byte, 01 half, 10 word.
- cpu_addr  in  ADDRESS_LENGTH  byte address.
- cpu_wdata  in  ADDRESS_LENGTH  store data, right-aligned.
- cpu_rdata  out  ADDRESS_LENGTH  word containing cpu_addr (word-aligned); byte/half extraction stays in the load unit.
- cpu_stall  out  1  freeze the pipeline.
- mem_a  out  ADDRESS_LENGTH  RAM address.
- mem_wd  out  ADDRESS_LENGTH  RAM write data.
- mem_sb / mem_sh / mem_sw  out  1 each  RAM store strobes, one-hot or all zero.
- mem_rd  in  ADDRESS_LENGTH  RAM word read data (combinational).

Behaviour:
- Address split: offset=addr[1:0], index=addr[INDEX_BITS+1:2], tag=addr[ADDRESS_LENGTH-1:INDEX_BITS+2].
- Per line: valid bit, tag, data word.
- Reset: all valid=0; state IDLE; counter=0; cpu_stall=0, cpu_rdata=0, mem strobes=0, mem_a=0, mem_wd=0.
- FSM states: IDLE, MISS_WAIT, FILL, WRITE.
- IDLE, no request, or load hit (valid && tag match):
  - cpu_rdata = line data, combinational, same cycle.
  - cpu_stall=0; stay in IDLE.
- IDLE, load miss:
  - cpu_stall=1 combinationally; go to MISS_WAIT; counter loaded with MEM_LATENCY-1.
  - mem_a = {addr[31:2],2'b00}.
- MISS_WAIT: cpu_stall=1; counter decrements; at 0 go to FILL.
- FILL:
  - Line gets data=mem_rd, tag, valid=1; cpu_rdata=mem_rd; cpu_stall=0; go to IDLE.
  - Total miss penalty = MEM_LATENCY+1 stall cycles.
  - The next cycle's re-presented load hits.
- IDLE, store:
  - cpu_stall=1 for exactly 1 cycle; go to WRITE.
- WRITE:
  - Exactly one strobe (per cpu_size) high for one cycle; mem_a=cpu_addr; mem_wd=cpu_wdata.
  - On hit: merge bytes into the cached word at byte lanes offset..offset+n-1.
  - On miss: cache unchanged.
  - cpu_stall=0; return to IDLE.
- Stores spanning a word boundary (half at offset 3, word at offset !=0):
  - RAM write passes through unchanged.
  - The hit line is invalidated instead of merged; a neighbouring line is never touched.
- cpu_size=11: treated as no-op; no strobe; no stall.
- rst in any state: the cycle after reset is IDLE, no strobe is issued, and the pending fill is discarded.
- mem strobes are never asserted outside WRITE.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined: adds outputs hit_count and miss_count, each 32 bits.
  - hit_count increments on each load hit in IDLE.
  - miss_count increments on entry to MISS_WAIT.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dcache_pkg:
  - state enum dcache_state_t {IDLE, MISS_WAIT, FILL, WRITE}.
  - size codes SIZE_B/SIZE_H/SIZE_W.
  - line struct {valid, tag, data}.
- One sub-module, dcache_array: valid/tag/data storage with combinational lookup, fill write, byte-lane merge and invalidate.
- The FSM and counter stay in dcache_ctrl.

Test Plan:
- Reset, then load 0x10000 (RAM word 0xDEADBEEF), MEM_LATENCY=2 -> cpu_stall high 3 cycles; cpu_rdata=0xDEADBEEF in FILL; immediate reload hits with stall=0.
- Word store 0x11223344 to cached 0x10000 -> 1 stall cycle, mem_sw pulses once, mem_a=0x10000; next load returns 0x11223344 with no stall.
- Byte store 0xAB to 0x10002 with the line cached as 0x11223344 -> mem_sb one cycle; subsequent hit returns 0x11AB3344.
- Load 0x10000 then 0x10020 (same index, SETS=8) -> both miss; reload 0x10000 misses again (conflict eviction).
- Half store at 0x10003 on a cached line -> mem_sh pulses, line invalidated; next load of 0x10000 misses.
- Assert rst during MISS_WAIT -> next cycle IDLE, cpu_stall=0, no strobes, line stays invalid.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types for the direct-mapped write-through data cache.
// State encoding, access-size codes, line layout and a store-span helper.
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, MISS_WAIT, FILL, WRITE} dcache_state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int LINE_W = 32;

    // Tag is held zero-extended to the full word width.
    typedef struct packed {
        logic              valid;
        logic [LINE_W-1:0] tag;
        logic [LINE_W-1:0] data;
    } dcache_line_t;

    // True when a store at this offset/size would cross into the next word.
    function automatic logic store_spans(input logic [1:0] offset, input logic [1:0] size);
        case (size)
            SIZE_H:  return offset == 2'd3;
            SIZE_W:  return offset != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for dcache_ctrl: combinational lookup, fill, byte-lane merge
// and invalidate, all on the single index presented by the controller.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS       = 8,
    parameter int INDEX_BITS = $clog2(SETS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] idx,
    output dcache_line_t          line,
    input  logic                  fill_en,
    input  logic [LINE_W-1:0]     fill_tag,
    input  logic [LINE_W-1:0]     fill_data,
    input  logic                  merge_en,
    input  logic [1:0]            offset,
    input  logic [1:0]            size,
    input  logic [LINE_W-1:0]     wdata,
    input  logic                  inval_en
);

    dcache_line_t      lines [SETS];
    logic [LINE_W-1:0] lane_mask;
    logic [LINE_W-1:0] lane_data;
    logic [LINE_W-1:0] merged;

    assign line = lines[idx];

    // Store data is right-aligned; shift it and its lane mask up to the byte offset.
    always_comb begin
        case (size)
            SIZE_B:  lane_mask = 32'h0000_00FF;
            SIZE_H:  lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        lane_mask = lane_mask << {offset, 3'b000};
        lane_data = wdata << {offset, 3'b000};
        merged    = (line.data & ~lane_mask) | (lane_data & lane_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) lines[i].valid <= 1'b0;
        end else if (fill_en) begin
            lines[idx] <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
        end else if (merge_en) begin
            lines[idx].data <= merged;
        end else if (inval_en) begin
            lines[idx].valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDRESS_LENGTH = 32,
    parameter int SETS           = 8,
    parameter int MEM_LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [1:0]                cpu_size,
    input  logic [ADDRESS_LENGTH-1:0] cpu_addr,
    input  logic [ADDRESS_LENGTH-1:0] cpu_wdata,
    output logic [ADDRESS_LENGTH-1:0] cpu_rdata,
    output logic                      cpu_stall,
    output logic [ADDRESS_LENGTH-1:0] mem_a,
    output logic [ADDRESS_LENGTH-1:0] mem_wd,
    output logic                      mem_sb,
    output logic                      mem_sh,
    output logic                      mem_sw,
    input  logic [ADDRESS_LENGTH-1:0] mem_rd
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
`endif
);

    localparam int INDEX_BITS = $clog2(SETS);
    localparam int CNT_W      = $clog2(MEM_LATENCY) + 1;

    dcache_state_t             state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [INDEX_BITS-1:0]     idx;
    logic [1:0]                offset;
    logic [LINE_W-1:0]         tag_ext;
    logic [ADDRESS_LENGTH-1:0] word_addr;
    dcache_line_t              line;
    logic                      hit, load_req, store_req;
    logic                      fill_en, merge_en, inval_en;

    assign offset    = cpu_addr[1:0];
    assign idx       = cpu_addr[INDEX_BITS+1:2];
    assign tag_ext   = LINE_W'(cpu_addr[ADDRESS_LENGTH-1:INDEX_BITS+2]);
    assign word_addr = {cpu_addr[ADDRESS_LENGTH-1:2], 2'b00};
    assign hit       = line.valid && (line.tag == tag_ext);
    assign load_req  = cpu_req && !cpu_we && (cpu_size != 2'b11);
    assign store_req = cpu_req &&  cpu_we && (cpu_size != 2'b11);

    dcache_array #(.SETS(SETS), .INDEX_BITS(INDEX_BITS)) u_array (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .line      (line),
        .fill_en   (fill_en),
        .fill_tag  (tag_ext),
        .fill_data (mem_rd),
        .merge_en  (merge_en),
        .offset    (offset),
        .size      (cpu_size),
        .wdata     (cpu_wdata),
        .inval_en  (inval_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && load_req && !hit)
                cnt <= CNT_W'(MEM_LATENCY - 1);
            else if (state == MISS_WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    // Everything is held at zero while rst is high so no strobe or fill leaks out.
    always_comb begin
        state_nxt = state;
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        mem_a     = '0;
        mem_wd    = '0;
        mem_sb    = 1'b0;
        mem_sh    = 1'b0;
        mem_sw    = 1'b0;
        fill_en   = 1'b0;
        merge_en  = 1'b0;
        inval_en  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    cpu_rdata = line.valid ? line.data : '0;
                    if (load_req && !hit) begin
                        cpu_stall = 1'b1;
                        mem_a     = word_addr;
                        state_nxt = MISS_WAIT;
                    end else if (store_req) begin
                        cpu_stall = 1'b1;
                        state_nxt = WRITE;
                    end
                end
                MISS_WAIT: begin
                    cpu_stall = 1'b1;
                    mem_a     = word_addr;
                    if (cnt == '0) state_nxt = FILL;
                end
                FILL: begin
                    mem_a     = word_addr;
                    cpu_rdata = mem_rd;
                    fill_en   = 1'b1;
                    state_nxt = IDLE;
                end
                WRITE: begin
                    mem_a  = cpu_addr;
                    mem_wd = cpu_wdata;
                    mem_sb = (cpu_size == SIZE_B);
                    mem_sh = (cpu_size == SIZE_H);
                    mem_sw = (cpu_size == SIZE_W);
                    // A store crossing the word cannot be merged into one line; drop the line.
                    if (hit) begin
                        if (store_spans(offset, cpu_size)) inval_en = 1'b1;
                        else                               merge_en = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE) begin
            if (load_req && hit && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 1'b1;
            if (load_req && !hit && miss_count != 32'hFFFF_FFFF)
                miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule
